// File: rtl/hazard_sched.sv
// Hazard/execute scheduler: EX forwarding, load-use stall, branch flush, multi-cycle op sequencing.
// Optional HAZARD_PERF_EN adds stall_cnt/flush_cnt performance counters.
module hazard_sched #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       MulOpE,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       mul_start,
    output logic       mul_done,
    output logic       mul_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_lw_stall;
    logic             w_mul_stall;

    always_comb begin
        forwardAE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (Rs1E == RdM)) begin
            forwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (Rs1E == RdW)) begin
            forwardAE = 2'b01;
        end
    end

    always_comb begin
        forwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (Rs2E == RdM)) begin
            forwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (Rs2E == RdW)) begin
            forwardBE = 2'b01;
        end
    end

    assign w_lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

    // Reset gates the IDLE start term so no stall or start leaks out while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mul_stall = 1'b0;
        mul_start   = 1'b0;
        mul_done    = 1'b0;
        if (r_state == ST_IDLE) begin
            if (MulOpE && !reset) begin
                mul_start   = 1'b1;
                w_mul_stall = 1'b1;
                w_state_nxt = ST_BUSY;
                w_cnt_nxt   = CNT_LOAD;
            end
        end else if (r_cnt != '0) begin
            w_mul_stall = 1'b1;
            w_cnt_nxt   = r_cnt - 1'b1;
        end else begin
            mul_done    = 1'b1;
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign mul_busy = (r_state == ST_BUSY);
    assign stallF   = w_lw_stall | w_mul_stall;
    assign stallD   = w_lw_stall | w_mul_stall;
    assign stallE   = w_mul_stall;
    assign flushM   = w_mul_stall;
    assign flushD   = PCSrcE & ~w_mul_stall;
    assign flushE   = (w_lw_stall | PCSrcE) & ~w_mul_stall;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stallF) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flushE) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched; expected outputs come from a phase-counting reference model.
module tb_hazard_sched;

    localparam int MUL_CYCLES = 4;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, ld, pcs, mul;
    } stim_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       sf, sd, se, fd, fe, fm, st, dn, bz;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulOpE;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, flushD, flushE, flushM;
    logic       mul_start, mul_done, mul_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_phase  = 0;
    int   m_stalls = 0;
    int   m_flushes = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    hazard_sched #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcE0(ResultSrcE0),
        .PCSrcE     (PCSrcE),
        .MulOpE     (MulOpE),
        .forwardAE  (forwardAE),
        .forwardBE  (forwardBE),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .flushD     (flushD),
        .flushE     (flushE),
        .flushM     (flushM),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_busy   (mul_busy)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input stim_t s);
        if (s.rwm && s.rdm != 0 && rs == s.rdm) return 2'b10;
        if (s.rww && s.rdw != 0 && rs == s.rdw) return 2'b01;
        return 2'b00;
    endfunction

    // Model counts cycles into the op (1..MUL_CYCLES-1) instead of counting down.
    function automatic exp_t model(input stim_t s, input int phase);
        exp_t e;
        logic lw, ms;
        e    = '0;
        e.fa = fwd_ref(s.rs1e, s);
        e.fb = fwd_ref(s.rs2e, s);
        lw   = s.ld && s.rde != 0 && (s.rs1d == s.rde || s.rs2d == s.rde);
        ms   = 1'b0;
        if (phase == 0) begin
            ms   = s.mul;
            e.st = s.mul;
        end else begin
            e.bz = 1'b1;
            if (phase == MUL_CYCLES - 1) e.dn = 1'b1;
            else ms = 1'b1;
        end
        e.sf = lw | ms;
        e.sd = lw | ms;
        e.se = ms;
        e.fm = ms;
        e.fd = s.pcs & ~ms;
        e.fe = (lw | s.pcs) & ~ms;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
        RdE = s.rde; RdM = s.rdm; RdW = s.rdw;
        RegWriteM = s.rwm; RegWriteW = s.rww; ResultSrcE0 = s.ld;
        PCSrcE = s.pcs; MulOpE = s.mul;
    endtask

    // One clock cycle: drive, push expectation, compare at negedge, advance model at posedge.
    task automatic step(input string tag, input stim_t s);
        exp_t e, g;
        apply(s);
        e = model(s, m_phase);
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        check({tag, ".fwdA"},  {30'd0, forwardAE}, {30'd0, g.fa});
        check({tag, ".fwdB"},  {30'd0, forwardBE}, {30'd0, g.fb});
        check({tag, ".stallF"}, {31'd0, stallF},   {31'd0, g.sf});
        check({tag, ".stallD"}, {31'd0, stallD},   {31'd0, g.sd});
        check({tag, ".stallE"}, {31'd0, stallE},   {31'd0, g.se});
        check({tag, ".flushD"}, {31'd0, flushD},   {31'd0, g.fd});
        check({tag, ".flushE"}, {31'd0, flushE},   {31'd0, g.fe});
        check({tag, ".flushM"}, {31'd0, flushM},   {31'd0, g.fm});
        check({tag, ".start"},  {31'd0, mul_start}, {31'd0, g.st});
        check({tag, ".done"},   {31'd0, mul_done},  {31'd0, g.dn});
        check({tag, ".busy"},   {31'd0, mul_busy},  {31'd0, g.bz});
        if (g.sf) m_stalls++;
        if (g.fe) m_flushes++;
        if (m_phase == 0) m_phase = g.st ? 1 : 0;
        else if (m_phase == MUL_CYCLES - 1) m_phase = 0;
        else m_phase++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s;
        s = '0;
        apply(s);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", {31'd0, mul_busy}, 32'd0);
        check("rst.stallE", {31'd0, stallE}, 32'd0);
        reset = 1'b0;
`ifdef HAZARD_PERF_EN
        check("rst.stall_cnt", stall_cnt, 32'd0);
        check("rst.flush_cnt", flush_cnt, 32'd0);
`endif

        // Forwarding priority and x0 handling
        s = '0; s.rdm = 5; s.rwm = 1; s.rs1e = 5;
        step("fwd_m", s);
        check("fwd_m.A10", {30'd0, forwardAE}, 32'd2);
        s.rdw = 5; s.rww = 1;
        step("fwd_mw", s);
        s.rwm = 0;
        step("fwd_w", s);
        check("fwd_w.A01", {30'd0, forwardAE}, 32'd1);
        s = '0; s.rs2e = 0; s.rdm = 0; s.rwm = 1; s.rs1e = 3;
        step("fwd_x0", s);
        s = '0; s.rs2e = 9; s.rdw = 9; s.rww = 1; s.rdm = 4; s.rwm = 1;
        step("fwd_bw", s);

        // Load-use: stall lasts only while the load sits in E
        s = '0; s.ld = 1; s.rde = 7; s.rs2d = 7;
        step("lw", s);
        check("lw.flushE1", {31'd0, flushE}, 32'd1);
        s = '0;
        step("lw_after", s);
        s = '0; s.ld = 1; s.rde = 0; s.rs1d = 0;
        step("lw_x0", s);

        // Back-to-back multi-cycle ops with MulOpE held high
        s = '0; s.mul = 1;
        for (int i = 0; i < 2 * MUL_CYCLES; i++) step($sformatf("mul%0d", i), s);
        s = '0;
        step("mul_idle", s);

        // Branch alone, branch with load-use, branch masked by a multi-cycle hold
        s = '0; s.pcs = 1;
        step("br", s);
        s.ld = 1; s.rde = 6; s.rs1d = 6;
        step("br_lw", s);
        s = '0; s.mul = 1;
        step("br_mul0", s);
        s.pcs = 1;
        step("br_mul1", s);
        s.pcs = 0;
        step("br_mul2", s);
        step("br_mul3", s);
        s = '0;
        step("br_idle", s);

        // Asynchronous reset in cycle 1 of an op
        s = '0; s.mul = 1;
        step("rmid0", s);
        #2;
        reset = 1'b1;
        #1;
        check("rmid.busy", {31'd0, mul_busy}, 32'd0);
        check("rmid.stallE", {31'd0, stallE}, 32'd0);
        check("rmid.start", {31'd0, mul_start}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_phase = 0;
        m_stalls = 0;
        m_flushes = 0;
        for (int i = 0; i < MUL_CYCLES; i++) step($sformatf("rmul%0d", i), s);
        s = '0; s.ld = 1; s.rde = 3; s.rs1d = 3;
        step("rlw", s);
        s = '0;
        step("rend", s);
`ifdef HAZARD_PERF_EN
        check("perf.stall_cnt", stall_cnt, 32'(m_stalls));
        check("perf.flush_cnt", flush_cnt, 32'(m_flushes));
        check("perf.stall_cnt4", stall_cnt, 32'd4);
        check("perf.flush_cnt1", flush_cnt, 32'd1);
`endif
        check("sb.empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
